// File: rtl/multiword_sub_seq_pkg.sv
// Shared constants for the sequential multi-word subtractor: state encoding,
// slice width and the index-width helper.
package multiword_sub_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multiword_sub_seq_if.sv
// Request/result bundle between the requester (master) and the sequential
// subtractor (slave).
interface multiword_sub_seq_if #(
    parameter int WORDS = 4
);
    logic                 start;
    logic [4*WORDS-1:0]   a;
    logic [4*WORDS-1:0]   b;
    logic                 busy;
    logic                 done;
    logic [4*WORDS-1:0]   diff;
    logic                 bout;
    logic                 zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, zero
    );
endinterface

// File: rtl/multiword_sub_seq_slice.sv
// Combinational 4-bit ripple-borrow subtractor: {bout, diff} = a - b - bin.
module slice_sub_4b
    import multiword_sub_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] diff,
    output logic               bout
);
    logic [SLICE_W:0] brw;

    always_comb begin
        brw    = '0;
        diff   = '0;
        brw[0] = bin;
        for (int i = 0; i < SLICE_W; i++) begin
            diff[i]  = a[i] ^ b[i] ^ brw[i];
            brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
        bout = brw[SLICE_W];
    end
endmodule

// File: rtl/multiword_sub_seq.sv
// Sequential A - B over WORDS 4-bit slices, LSB slice first, borrow carried
// between cycles in a register.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; result registers hold the last result
//   ST_RUN  | one slice per edge, WORDS edges
//   ST_DONE | single cycle with done high; start here is accepted back-to-back
module multiword_sub_seq
    import multiword_sub_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    multiword_sub_seq_if.slave  bus
);
    localparam int N  = SLICE_W * WORDS;
    localparam int IW = clog2(WORDS);

    state_t               state;
    logic [N-1:0]         a_reg;
    logic [N-1:0]         b_reg;
    logic [N-1:0]         diff_q;
    logic [N-1:0]         diff_next;
    logic                 borrow_q;
    logic [IW-1:0]        idx;
    logic                 busy_q;
    logic                 done_q;
    logic                 bout_q;
    logic                 zero_q;
    logic [SLICE_W-1:0]   slice_diff;
    logic                 slice_bout;
    logic                 last_slice;

    slice_sub_4b u_slice (
        .a    (a_reg[SLICE_W-1:0]),
        .b    (b_reg[SLICE_W-1:0]),
        .bin  (borrow_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    // Zero flag must see the slice being written this edge, not the stale diff.
    always_comb begin
        diff_next = diff_q;
        diff_next[idx*SLICE_W +: SLICE_W] = slice_diff;
    end

    assign last_slice = (idx == IW'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            idx      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state    <= ST_RUN;
                        a_reg    <= bus.a;
                        b_reg    <= bus.b;
                        diff_q   <= '0;
                        borrow_q <= 1'b0;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        bout_q   <= 1'b0;
                        zero_q   <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    diff_q   <= diff_next;
                    borrow_q <= slice_bout;
                    a_reg    <= a_reg >> SLICE_W;
                    b_reg    <= b_reg >> SLICE_W;
                    idx      <= idx + 1'b1;
                    if (last_slice) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        bout_q <= slice_bout;
                        zero_q <= (diff_next == '0);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule
